// File: rtl/mlaccel_pkg.sv
// rtl/mlaccel_pkg.sv - shared widths, client enum and latency tag type for the mlaccel memory path
package mlaccel_pkg;
    localparam int MLACCEL_ADDR_W      = 16;
    localparam int MLACCEL_MEM_RDATA_W = 64;

    typedef enum logic [1:0] {
        NONE,
        CMEM,
        QMEM,
        SMEM
    } client_e;

    typedef struct packed {
        logic hrd;
        logic seq;
    } tag_t;
endpackage

// File: rtl/mlaccel_memarb_tagpipe.sv
// rtl/mlaccel_memarb_tagpipe.sv - MEM_LAT-deep shift register of {host-read, seq} tags
module mlaccel_memarb_tagpipe
    import mlaccel_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic in_hrd,
    input  logic in_seq,
    output logic out_hrd,
    output logic out_seq
);

    tag_t pipe [0:MEM_LAT-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{hrd: in_hrd, seq: in_seq};
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Last stage is registered, so a tag entered on the grant cycle emerges MEM_LAT cycles later.
    assign out_hrd = pipe[MEM_LAT-1].hrd;
    assign out_seq = pipe[MEM_LAT-1].seq;

endmodule

// File: rtl/mlaccel_memarb.sv
// rtl/mlaccel_memarb.sv - compute/host/sequencer memory arbiter; MLACCEL_MEMARB_FAIR_EN enables host/seq round-robin
module mlaccel_memarb
    import mlaccel_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           cmem_ren,
    input  logic [1:0]                     cmem_wen,
    input  logic [MLACCEL_ADDR_W-1:0]      cmem_addr,
    input  logic [15:0]                    cmem_wdata,
    output logic [MLACCEL_MEM_RDATA_W-1:0] cmem_rdata,
    input  logic                           q_req,
    input  logic [1:0]                     q_write,
    input  logic [MLACCEL_ADDR_W-1:0]      q_addr,
    input  logic [15:0]                    q_wdata,
    output logic                           q_done,
    output logic                           q_rvalid,
    output logic [15:0]                    q_rdata,
    input  logic                           s_valid,
    input  logic [MLACCEL_ADDR_W-1:0]      s_addr,
    output logic                           s_ready,
    output logic [31:0]                    s_data,
    output logic [MLACCEL_ADDR_W-1:0]      mem_addr,
    output logic [1:0]                     mem_wen,
    output logic [15:0]                    mem_wdata,
    input  logic [MLACCEL_MEM_RDATA_W-1:0] mem_rdata
);

    client_e grant;
    logic    c_act;
    logic    q_elig;
    logic    s_elig;
    logic    s_inflight;
    logic    pick_seq;

    assign c_act  = cmem_ren | (|cmem_wen);
    assign q_elig = q_req & ~q_done;
    assign s_elig = s_valid & ~s_inflight;

`ifdef MLACCEL_MEMARB_FAIR_EN
    logic last_host;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_host <= 1'b0;
        end else if (grant == QMEM) begin
            last_host <= 1'b1;
        end else if (grant == SMEM) begin
            last_host <= 1'b0;
        end
    end

    assign pick_seq = last_host;
`else
    assign pick_seq = 1'b0;
`endif

    always_comb begin
        grant = NONE;
        if (reset) begin
            grant = NONE;
        end else if (c_act) begin
            grant = CMEM;
        end else if (q_elig && s_elig) begin
            grant = pick_seq ? SMEM : QMEM;
        end else if (q_elig) begin
            grant = QMEM;
        end else if (s_elig) begin
            grant = SMEM;
        end
    end

    // Idle cycles leave the compute address on the bus so compute sees no added path delay.
    always_comb begin
        mem_addr  = cmem_addr;
        mem_wen   = 2'b00;
        mem_wdata = cmem_wdata;
        case (grant)
            CMEM: mem_wen = cmem_wen;
            QMEM: begin
                mem_addr  = q_addr;
                mem_wen   = q_write;
                mem_wdata = q_wdata;
            end
            SMEM: mem_addr = s_addr;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_done     <= 1'b0;
            s_inflight <= 1'b0;
        end else begin
            q_done <= (grant == QMEM);
            if (grant == SMEM) begin
                s_inflight <= 1'b1;
            end else if (s_ready) begin
                s_inflight <= 1'b0;
            end
        end
    end

    mlaccel_memarb_tagpipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tagpipe (
        .clock   (clock),
        .reset   (reset),
        .in_hrd  ((grant == QMEM) && (q_write == 2'b00)),
        .in_seq  (grant == SMEM),
        .out_hrd (q_rvalid),
        .out_seq (s_ready)
    );

    assign cmem_rdata = mem_rdata;
    assign q_rdata    = mem_rdata[15:0];
    assign s_data     = mem_rdata[31:0];

endmodule

// File: tb/tb_mlaccel_memarb.sv
// tb/tb_mlaccel_memarb.sv - table-driven bench for mlaccel_memarb with MEM_LAT=2
module tb_mlaccel_memarb;

    localparam logic [15:0] CW = 16'hC0DE;
    localparam logic [15:0] QW = 16'h0A0A;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmem_ren;
    logic [1:0]  cmem_wen;
    logic [15:0] cmem_addr;
    logic [15:0] cmem_wdata;
    logic [63:0] cmem_rdata;
    logic        q_req;
    logic [1:0]  q_write;
    logic [15:0] q_addr;
    logic [15:0] q_wdata;
    logic        q_done;
    logic        q_rvalid;
    logic [15:0] q_rdata;
    logic        s_valid;
    logic [15:0] s_addr;
    logic        s_ready;
    logic [31:0] s_data;
    logic [15:0] mem_addr;
    logic [1:0]  mem_wen;
    logic [15:0] mem_wdata;
    logic [63:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    mlaccel_memarb #(.MEM_LAT(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmem_ren   (cmem_ren),
        .cmem_wen   (cmem_wen),
        .cmem_addr  (cmem_addr),
        .cmem_wdata (cmem_wdata),
        .cmem_rdata (cmem_rdata),
        .q_req      (q_req),
        .q_write    (q_write),
        .q_addr     (q_addr),
        .q_wdata    (q_wdata),
        .q_done     (q_done),
        .q_rvalid   (q_rvalid),
        .q_rdata    (q_rdata),
        .s_valid    (s_valid),
        .s_addr     (s_addr),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        cren;
        logic [1:0]  cwen;
        logic [15:0] caddr;
        logic        qreq;
        logic [1:0]  qwr;
        logic [15:0] qaddr;
        logic        sv;
        logic [15:0] saddr;
        logic [31:0] rd;
        logic [15:0] e_addr;
        logic [1:0]  e_wen;
        logic [15:0] e_wdata;
        logic        e_qd;
        logic        e_qrv;
        logic        e_sr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic cren, logic [1:0] cwen, logic [15:0] caddr,
                                logic qreq, logic [1:0] qwr, logic [15:0] qaddr,
                                logic sv, logic [15:0] saddr, logic [31:0] rd,
                                logic [15:0] e_addr, logic [1:0] e_wen, logic [15:0] e_wdata,
                                logic e_qd, logic e_qrv, logic e_sr);
        vec_t v;
        v.rst = rst; v.cren = cren; v.cwen = cwen; v.caddr = caddr;
        v.qreq = qreq; v.qwr = qwr; v.qaddr = qaddr;
        v.sv = sv; v.saddr = saddr; v.rd = rd;
        v.e_addr = e_addr; v.e_wen = e_wen; v.e_wdata = e_wdata;
        v.e_qd = e_qd; v.e_qrv = e_qrv; v.e_sr = e_sr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        reset = 1'b0; cmem_ren = 1'b0; cmem_wen = 2'b00; cmem_addr = 16'h0000; cmem_wdata = CW;
        q_req = 1'b0; q_write = 2'b00; q_addr = 16'h0000; q_wdata = QW;
        s_valid = 1'b0; s_addr = 16'h0000; mem_rdata = 64'h0;
    endtask

    logic [15:0] fair_exp [6];

    initial begin
        set_idle();
        reset = 1'b1;

        vecs.push_back(mk(1,0,0,16'h0000, 1,0,16'h0010, 1,16'h0100, 32'h0,      16'h0000,0,CW, 0,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 1,0,16'h0010, 0,16'h0000, 32'h0,      16'h0010,0,QW, 0,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 1,0,16'h0010, 0,16'h0000, 32'h0,      16'h0000,0,CW, 1,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,16'h0000, 32'h1234,   16'h0000,0,CW, 0,1,0));
        vecs.push_back(mk(0,0,0,16'h0000, 1,0,16'h0020, 1,16'h0100, 32'h0,      16'h0020,0,QW, 0,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 1,0,16'h0020, 1,16'h0100, 32'h0,      16'h0100,0,CW, 1,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,16'h0000, 32'h5555,   16'h0000,0,CW, 0,1,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,16'h0000, 32'hABCDEF, 16'h0000,0,CW, 0,0,1));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(0,0,3,16'h0300, 1,0,16'h0030, 0,16'h0000, 32'h0,  16'h0300,3,CW, 0,0,0));
        end
        vecs.push_back(mk(0,0,0,16'h0000, 1,0,16'h0030, 0,16'h0000, 32'h0,      16'h0030,0,QW, 0,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 1,0,16'h0030, 0,16'h0000, 32'h0,      16'h0000,0,CW, 1,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,16'h0000, 32'h0F0F,   16'h0000,0,CW, 0,1,0));
        vecs.push_back(mk(0,0,0,16'h0000, 1,1,16'h0040, 0,16'h0000, 32'h0,      16'h0040,1,QW, 0,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,16'h0000, 32'h0,      16'h0000,0,CW, 1,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,16'h0000, 32'h0,      16'h0000,0,CW, 0,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,16'h0000, 32'h0,      16'h0000,0,CW, 0,0,0));
        vecs.push_back(mk(0,1,0,16'h0500, 0,0,16'h0000, 1,16'h0100, 32'h0,      16'h0500,0,CW, 0,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 1,16'h0100, 32'h0,      16'h0100,0,CW, 0,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 1,16'h0100, 32'h0,      16'h0000,0,CW, 0,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 1,16'h0100, 32'h7777,   16'h0000,0,CW, 0,0,1));
        vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 1,16'h0100, 32'h0,      16'h0100,0,CW, 0,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,16'h0000, 32'h0,      16'h0000,0,CW, 0,0,0));
        vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,16'h0000, 32'h0,      16'h0000,0,CW, 0,0,1));
        vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,16'h0000, 32'h0,      16'h0000,0,CW, 0,0,0));

        @(posedge clock);
        foreach (vecs[i]) begin
            @(negedge clock);
            reset = vecs[i].rst; cmem_ren = vecs[i].cren; cmem_wen = vecs[i].cwen;
            cmem_addr = vecs[i].caddr; q_req = vecs[i].qreq; q_write = vecs[i].qwr;
            q_addr = vecs[i].qaddr; s_valid = vecs[i].sv; s_addr = vecs[i].saddr;
            mem_rdata = {32'hDEAD_BEEF, vecs[i].rd};
            #2;
            chk($sformatf("row%0d ctl", i),
                {87'd0, mem_addr, mem_wen, mem_wdata, q_done, q_rvalid, s_ready},
                {87'd0, vecs[i].e_addr, vecs[i].e_wen, vecs[i].e_wdata, vecs[i].e_qd, vecs[i].e_qrv, vecs[i].e_sr});
            chk($sformatf("row%0d data", i),
                {16'd0, q_rdata, s_data, cmem_rdata},
                {16'd0, vecs[i].rd[15:0], vecs[i].rd, 32'hDEAD_BEEF, vecs[i].rd});
        end

        // Reset one cycle after a sequencer grant must swallow its s_ready.
        @(negedge clock);
        set_idle(); cmem_wdata = 16'h0000; s_valid = 1'b1; s_addr = 16'h0100;
        #2 chk("rst_seq_grant", {112'd0, mem_addr}, {112'd0, 16'h0100});
        @(negedge clock);
        reset = 1'b1;
        #2 chk("no_grant_in_reset", {111'd0, mem_addr, mem_wen, s_ready}, {111'd0, 16'h0000, 2'b00, 1'b0});
        @(negedge clock);
        reset = 1'b0; s_valid = 1'b0;
        #2 chk("outputs_zero_after_reset",
               {cmem_rdata, q_done, q_rvalid, q_rdata, s_ready, s_data, mem_addr, mem_wen, mem_wdata},
               128'd0);
        @(negedge clock);
        s_valid = 1'b1;
        #2 chk("inflight_cleared", {111'd0, mem_addr, s_ready}, {111'd0, 16'h0100, 1'b0});
        @(negedge clock);
        set_idle();
        repeat (3) @(negedge clock);

        // Host and sequencer both held: grant order depends on the arbitration build.
`ifdef MLACCEL_MEMARB_FAIR_EN
        fair_exp = '{16'h0AAA, 16'h0BBB, 16'h0AAA, 16'h0CCC, 16'h0BBB, 16'h0AAA};
`else
        fair_exp = '{16'h0AAA, 16'h0BBB, 16'h0AAA, 16'h0CCC, 16'h0AAA, 16'h0BBB};
`endif
        cmem_addr = 16'h0CCC; q_req = 1'b1; q_addr = 16'h0AAA; s_valid = 1'b1; s_addr = 16'h0BBB;
        for (int k = 0; k < 6; k++) begin
            #2 chk($sformatf("arb_order%0d", k), {112'd0, mem_addr}, {112'd0, fair_exp[k]});
            @(negedge clock);
        end
        set_idle();
        repeat (4) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mlaccel_memarb.md
MLACCEL_MEMARB -- requirements
Module: mlaccel_memarb

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2: cycles from address on mem_addr to valid mem_rdata; legal 1..4.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- cmem_ren  in  1  compute read request
- cmem_wen  in  2  compute byte write enables
- cmem_addr  in  16  compute word address
- cmem_wdata  in  16  compute write data
- cmem_rdata  out  64  compute read data, pass-through of mem_rdata
- q_req  in  1  host access request, held until q_done
- q_write  in  2  host byte write enables; 0 means read
- q_addr  in  16  host word address
- q_wdata  in  16  host write data
- q_done  out  1  host grant-accepted pulse
- q_rvalid  out  1  host read-data-valid pulse
- q_rdata  out  16  host read data, mem_rdata[15:0]
- s_valid  in  1  sequencer fetch request
- s_addr  in  16  sequencer fetch address
- s_ready  out  1  sequencer fetch-data-valid pulse
- s_data  out  32  sequencer fetch data, mem_rdata[31:0]
- mem_addr  out  16  memory address
- mem_wen  out  2  memory byte write enables
- mem_wdata  out  16  memory write data
- mem_rdata  in  64  memory read data

Function
REQ-003 SHALL grant compute whenever cmem_ren or cmem_wen is nonzero; compute always wins, is never stalled and has no handshake.
REQ-004 SHALL grant host, when compute is idle, only if q_req=1 and q_done=0 in the current cycle.
REQ-005 SHALL grant sequencer, when compute is idle, only if s_valid=1 and no sequencer fetch is in flight.
REQ-006 SHALL, without the configuration macro, give host priority over sequencer.
REQ-007 SHALL drive mem_addr, mem_wen and mem_wdata combinationally from the granted client; mem_wen=0 for sequencer grants.
REQ-008 SHALL drive mem_addr=cmem_addr and mem_wen=0 when no client is granted.
REQ-009 SHALL pulse q_done exactly 1 cycle after a host grant.
REQ-010 SHALL pulse q_rvalid exactly MEM_LAT cycles after a host read grant, and never for a host write grant.
REQ-011 SHALL pulse s_ready exactly MEM_LAT cycles after a sequencer grant.
REQ-012 SHALL keep the sequencer in flight from its grant through its s_ready cycle inclusive, so at most 1 fetch is outstanding.
REQ-013 SHALL track latency with a MEM_LAT-deep shift register of {host-read, seq} tags; a host read and a sequencer fetch may be in flight together.
REQ-014 SHALL let a host keep q_req asserted after q_done; the next host grant occurs no earlier than 2 cycles after the previous one.
REQ-015 SHALL, under continuous compute access, starve host and sequencer indefinitely and raise no error.

Reset
REQ-016 SHALL clear q_done, q_rvalid, s_ready, the in-flight flag, the tag pipeline and the fairness pointer on reset.
REQ-017 SHALL suppress all pending q_rvalid and s_ready pulses when reset is asserted mid-operation.
REQ-018 SHALL grant nothing while reset=1.

Configuration
REQ-019 SHALL, with MLACCEL_MEMARB_FAIR_EN defined, arbitrate host and sequencer round-robin.
- A 1-bit last-winner pointer selects the other client when both are eligible.
- Without the macro: fixed host priority and no pointer register.

Structure
REQ-020 SHALL take MLACCEL_ADDR_W=16, MLACCEL_MEM_RDATA_W=64 and a client enum (NONE, CMEM, QMEM, SMEM) from shared package mlaccel_pkg.
REQ-021 SHALL implement the tag pipeline as sub-module mlaccel_memarb_tagpipe, parameterised by MEM_LAT.

Verification
REQ-022 SHALL cover these directed scenarios:
- Host read q_addr=0x0010, memory returns 0x1234 -> q_done at +1, q_rvalid with q_rdata=0x1234 at +2 (MEM_LAT=2).
- s_valid and q_req asserted in the same cycle, no compute -> host granted first; sequencer granted next cycle; fair build alternates grants.
- cmem_wen=3 held for 5 cycles while q_req=1 -> no q_done during those cycles; q_done 1 cycle after cmem_wen drops.
- s_valid held high with s_addr=0x0100 -> grants 3 cycles apart; s_ready at +2 each; never 2 fetches outstanding.
- reset asserted 1 cycle after a sequencer grant -> no s_ready; all outputs 0 the following cycle.
- Host write q_write=2'b01 -> mem_wen=01 on the grant cycle; q_done; no q_rvalid.
